// File: rtl/alu_seq.sv
// Handshaked sequential ALU: add/shift/logic in one cycle, iterative shift-add multiply, optional divider (ALU_SEQ_DIV_EN).
// Latency 1 for add/shift/logic/illegal, WIDTH+1 for mul/div; a result is held until out_ready, and a new op may enter as it drains.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [3:0]       op1,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_lo,
   output logic [WIDTH-1:0] out_hi,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             N,
   output logic             err
);

   localparam int M = WIDTH - 1;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SHF = 4'd1;
   localparam logic [3:0] OP_LOG = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [3:0] OP_DIV = 4'd4;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_q, neg_d;
   logic               sgn_q, sgn_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               c_q, c_d;
   logic               v_q, v_d;
   logic               z_q, z_d;
   logic               n_q, n_d;
   logic               err_q, err_d;
`ifdef ALU_SEQ_DIV_EN
   logic               div_q, div_d;
   logic               dz_q, dz_d;
`endif

   logic accept;

   // Add unit: inc/dec reuse the adder with a constant 1 operand
   logic [WIDTH-1:0] add_opd;
   logic             add_sub;
   logic [WIDTH:0]   add_sum;
   logic             add_ovf;

   assign add_opd = op1[0] ? WIDTH'(1) : in1;
   assign add_sub = op1[1];
   assign add_sum = add_sub ? ({1'b0, in0} - {1'b0, add_opd})
                            : ({1'b0, in0} + {1'b0, add_opd});
   assign add_ovf = (add_sub ? (in0[M] != add_opd[M]) : (in0[M] == add_opd[M]))
                  & (add_sum[M] != in0[M]);

   // Shifts carry one extra bit so the last bit shifted out falls into it
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   shr_ext;
   logic [WIDTH:0]   sar_ext;
   logic [WIDTH-1:0] rol_res;

   assign shamt   = in1[SHW-1:0];
   assign shl_ext = {1'b0, in0} << shamt;
   assign shr_ext = {in0, 1'b0} >> shamt;
   assign sar_ext = $signed({in0, 1'b0}) >>> shamt;
   assign rol_res = (in0 << shamt) | ((in0 >> 1) >> (~shamt));

   logic [WIDTH-1:0] res_lo;
   logic             res_c;
   logic             res_v;
   logic             legal;
   logic             iter;

   always_comb begin
      res_lo = '0;
      res_c  = 1'b0;
      res_v  = 1'b0;
      legal  = 1'b0;
      iter   = 1'b0;
      case (op)
         OP_ADD: begin
            if (op1 < 4'd4) begin
               legal  = 1'b1;
               res_lo = add_sum[M:0];
               res_c  = add_sum[WIDTH];
               res_v  = add_ovf;
            end
         end
         OP_SHF: begin
            if (op1 < 4'd4) begin
               legal = 1'b1;
               case (op1[1:0])
                  2'd0: begin res_lo = shl_ext[M:0];     res_c = shl_ext[WIDTH]; end
                  2'd1: begin res_lo = shr_ext[WIDTH:1]; res_c = shr_ext[0];     end
                  2'd2: begin res_lo = sar_ext[WIDTH:1]; res_c = sar_ext[0];     end
                  2'd3: begin res_lo = rol_res;          res_c = 1'b0;           end
               endcase
            end
         end
         OP_LOG: begin
            if (op1 < 4'd4) begin
               legal = 1'b1;
               case (op1[1:0])
                  2'd0: res_lo = in0 & in1;
                  2'd1: res_lo = in0 | in1;
                  2'd2: res_lo = in0 ^ in1;
                  2'd3: res_lo = ~(in0 | in1);
               endcase
            end
         end
         OP_MUL: begin
            if (op1 < 4'd2) begin
               legal = 1'b1;
               iter  = 1'b1;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            if (op1 == 4'd0) begin
               legal = 1'b1;
               iter  = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // Signed multiply runs on magnitudes; the sign is restored at completion
   logic [WIDTH-1:0]   mag0;
   logic [WIDTH-1:0]   mag1;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic [2*WIDTH-1:0] mul_fin;
   logic               mul_ovf;

   assign mag0     = (op1[0] & in0[M]) ? -in0 : in0;
   assign mag1     = (op1[0] & in1[M]) ? -in1 : in1;
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_step = {mul_sum, prod_q[M:1]};
   assign mul_fin  = neg_q ? -mul_step : mul_step;
   assign mul_ovf  = sgn_q ? (mul_fin[2*WIDTH-1:WIDTH] != {WIDTH{mul_fin[M]}})
                           : (mul_fin[2*WIDTH-1:WIDTH] != '0);

`ifdef ALU_SEQ_DIV_EN
   // Restoring divide: {remainder, dividend/quotient} shift left one bit per cycle
   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] div_step;

   assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[M]};
   assign div_ge   = div_sh >= {1'b0, mcand_q};
   assign div_sub  = div_sh[M:0] - mcand_q;
   assign div_step = {(div_ge ? div_sub : div_sh[M:0]), prod_q[M-1:0], div_ge};
`endif

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      sgn_d   = sgn_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;
      err_d   = err_q;
`ifdef ALU_SEQ_DIV_EN
      div_d   = div_q;
      dz_d    = dz_q;
`endif
      case (state_q)
         S_BUSY: begin
            prod_d = mul_step;
`ifdef ALU_SEQ_DIV_EN
            if (div_q) prod_d = div_step;
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = S_DONE;
               lo_d    = mul_fin[M:0];
               hi_d    = mul_fin[2*WIDTH-1:WIDTH];
               c_d     = 1'b0;
               v_d     = mul_ovf;
               z_d     = (mul_fin == '0);
               n_d     = mul_fin[2*WIDTH-1];
               err_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
               if (div_q) begin
                  lo_d = div_step[M:0];
                  hi_d = div_step[2*WIDTH-1:WIDTH];
                  v_d  = dz_q;
                  z_d  = (div_step[M:0] == '0);
                  n_d  = div_step[M];
               end
`endif
            end
         end
         default: begin
            if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
            if (accept) begin
               if (iter) begin
                  state_d = S_BUSY;
                  cnt_d   = '0;
                  sgn_d   = op1[0];
                  neg_d   = op1[0] & (in0[M] ^ in1[M]);
                  mcand_d = mag0;
                  prod_d  = {{WIDTH{1'b0}}, mag1};
`ifdef ALU_SEQ_DIV_EN
                  div_d   = (op == OP_DIV);
                  dz_d    = (in1 == '0);
                  if (op == OP_DIV) begin
                     neg_d   = 1'b0;
                     mcand_d = in1;
                     prod_d  = {{WIDTH{1'b0}}, in0};
                  end
`endif
               end else begin
                  state_d = S_DONE;
                  lo_d    = res_lo;
                  hi_d    = '0;
                  c_d     = res_c;
                  v_d     = res_v;
                  // an illegal op reports all flags clear, including zero
                  z_d     = legal & (res_lo == '0);
                  n_d     = res_lo[M];
                  err_d   = ~legal;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         sgn_q   <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         sgn_q   <= sgn_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
         err_q   <= err_d;
`ifdef ALU_SEQ_DIV_EN
         div_q   <= div_d;
         dz_q    <= dz_d;
`endif
      end
   end

   assign out_lo   = lo_q;
   assign out_hi   = hi_q;
   assign carryout = c_q;
   assign overflow = v_q;
   assign zero     = z_q;
   assign N        = n_q;
   assign err      = err_q;

endmodule
